// File: rtl/lsq_ctrl_pkg.sv
// Shared types for the load/store queue RAM controllers: controller phase and
// the value written into every entry by the clear sequence.
package lsq_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    READY = 2'd1,
    CLEAR = 2'd2
  } state_e;

  // Wide enough for any entry width in use; callers take the low WIDTH bits.
  localparam int unsigned RESET_DATA_MAX_W = 64;
  localparam logic [RESET_DATA_MAX_W-1:0] RESET_DATA = '0;

endpackage

// File: rtl/stq_wr_conflict_resolve.sv
// Flags dispatch lanes that lose a same-address collision to a younger
// (higher-numbered) lane in the same cycle.
module stq_wr_conflict_resolve #(
  parameter int DISPATCH_WIDTH = 4,
  parameter int INDEX          = 4
) (
  input  logic [DISPATCH_WIDTH-1:0]       we_i,
  input  logic [DISPATCH_WIDTH*INDEX-1:0] addr_i,
  output logic [DISPATCH_WIDTH-1:0]       killed_o
);

  always_comb begin
    killed_o = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      for (int j = k + 1; j < DISPATCH_WIDTH; j++) begin
        if (we_i[j] && (addr_i[j*INDEX +: INDEX] == addr_i[k*INDEX +: INDEX])) begin
          killed_o[k] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stq_followingld_ctrl.sv
// Write-side controller for the store-queue following-load RAM: zero-fills the
// RAM after reset/flush, then forwards collision-free dispatch writes.
module stq_followingld_ctrl
  import lsq_ctrl_pkg::*;
#(
  parameter int DISPATCH_WIDTH = 4,
  parameter int DEPTH          = 16,
  parameter int INDEX          = 4,
  parameter int WIDTH          = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush_i,
  input  logic [DISPATCH_WIDTH-1:0]         dispWe_i,
  input  logic [DISPATCH_WIDTH*INDEX-1:0]   dispAddr_i,
  input  logic [DISPATCH_WIDTH*WIDTH-1:0]   dispData_i,
  output logic                              dispStall_o,
  output logic                              ramReady_o,
  output logic [DISPATCH_WIDTH-1:0]         we_o,
  output logic [DISPATCH_WIDTH*INDEX-1:0]   addrWr_o,
  output logic [DISPATCH_WIDTH*WIDTH-1:0]   dataWr_o
);

  localparam logic [INDEX-1:0] LAST_IDX = INDEX'(DEPTH - 1);

  state_e                            state_q, state_d;
  logic [INDEX-1:0]                  cnt_q, cnt_d;
  logic [DISPATCH_WIDTH-1:0]         we_q, we_d;
  logic [DISPATCH_WIDTH*INDEX-1:0]   addr_q, addr_d;
  logic [DISPATCH_WIDTH*WIDTH-1:0]   data_q, data_d;
  logic                              ready_q, ready_d;
  logic [DISPATCH_WIDTH-1:0]         killed;

  stq_wr_conflict_resolve #(
    .DISPATCH_WIDTH(DISPATCH_WIDTH),
    .INDEX         (INDEX)
  ) u_conflict (
    .we_i    (dispWe_i),
    .addr_i  (dispAddr_i),
    .killed_o(killed)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  // A flush always restarts the clear walk from entry 0, whatever the phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT, CLEAR: begin
        if (flush_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (cnt_q == LAST_IDX) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + INDEX'(1);
        end
      end
      READY: begin
        if (flush_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear writes use lane 0 only; a flush cycle issues no write at all.
  always_comb begin
    we_d    = '0;
    addr_d  = '0;
    data_d  = '0;
    ready_d = (state_d == READY);
    case (state_q)
      INIT, CLEAR: begin
        if (!flush_i) begin
          we_d[0]            = 1'b1;
          addr_d[INDEX-1:0]  = cnt_q;
          data_d[WIDTH-1:0]  = RESET_DATA[WIDTH-1:0];
        end
      end
      READY: begin
        addr_d = dispAddr_i;
        data_d = dispData_i;
        if (!flush_i) begin
          we_d = dispWe_i & ~killed;
        end
      end
      default: begin
        we_d = '0;
      end
    endcase
  end

  assign we_o        = we_q;
  assign addrWr_o    = addr_q;
  assign dataWr_o    = data_q;
  assign ramReady_o  = ready_q;
  assign dispStall_o = ~ready_q;

endmodule

// File: tb/tb_stq_followingld_ctrl.sv
// Self-checking bench for stq_followingld_ctrl: directed steps plus random
// dispatch traffic, checked against a behavioural model and a shadow RAM.
module tb_stq_followingld_ctrl;

  localparam int DW    = 4;
  localparam int DEPTH = 16;
  localparam int INDEX = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  flush_i;
  logic [DW-1:0]         dispWe_i;
  logic [DW*INDEX-1:0]   dispAddr_i;
  logic [DW*WIDTH-1:0]   dispData_i;
  logic                  dispStall_o;
  logic                  ramReady_o;
  logic [DW-1:0]         we_o;
  logic [DW*INDEX-1:0]   addrWr_o;
  logic [DW*WIDTH-1:0]   dataWr_o;

  int checks = 0;
  int errors = 0;

  // Model state: whether a clear walk is in progress and how far it has got.
  bit                    mClearing;
  int                    mIdx;
  bit                    mReady;
  logic [DW-1:0]         expWe;
  logic [INDEX-1:0]      expAddr [DW];
  logic [WIDTH-1:0]      expData [DW];
  logic [WIDTH-1:0]      modelRam [DEPTH];
  logic [WIDTH-1:0]      dutRam [DEPTH];

  stq_followingld_ctrl #(
    .DISPATCH_WIDTH(DW),
    .DEPTH         (DEPTH),
    .INDEX         (INDEX),
    .WIDTH         (WIDTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush_i),
    .dispWe_i   (dispWe_i),
    .dispAddr_i (dispAddr_i),
    .dispData_i (dispData_i),
    .dispStall_o(dispStall_o),
    .ramReady_o (ramReady_o),
    .we_o       (we_o),
    .addrWr_o   (addrWr_o),
    .dataWr_o   (dataWr_o)
  );

  always #5 clk = ~clk;

  // Shadow RAM fed only by what the DUT actually presents.
  always @(posedge clk) begin
    for (int k = 0; k < DW; k++) begin
      if (we_o[k] === 1'b1) dutRam[addrWr_o[k*INDEX +: INDEX]] <= dataWr_o[k*WIDTH +: WIDTH];
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelEdge(input bit r, input bit f, input logic [DW-1:0] we,
                           input logic [DW*INDEX-1:0] addr, input logic [DW*WIDTH-1:0] data);
    bit youngest;
    for (int k = 0; k < DW; k++) begin
      if (expWe[k]) modelRam[expAddr[k]] = expData[k];
    end
    expWe = '0;
    if (r) begin
      mClearing = 1'b1;
      mIdx      = 0;
    end else if (mClearing) begin
      if (f) begin
        mIdx = 0;
      end else begin
        expWe[0]   = 1'b1;
        expAddr[0] = INDEX'(mIdx);
        expData[0] = '0;
        mIdx++;
        if (mIdx == DEPTH) begin
          mClearing = 1'b0;
          mIdx      = 0;
        end
      end
    end else if (f) begin
      mClearing = 1'b1;
      mIdx      = 0;
    end else begin
      for (int k = 0; k < DW; k++) begin
        if (we[k]) begin
          youngest = 1'b1;
          for (int j = k + 1; j < DW; j++) begin
            if (we[j] && addr[j*INDEX +: INDEX] == addr[k*INDEX +: INDEX]) youngest = 1'b0;
          end
          if (youngest) begin
            expWe[k]   = 1'b1;
            expAddr[k] = addr[k*INDEX +: INDEX];
            expData[k] = data[k*WIDTH +: WIDTH];
          end
        end
      end
    end
    mReady = !mClearing;
  endtask

  task automatic checkOutput();
    checkVal("we_o", 32'(we_o), 32'(expWe));
    checkVal("ramReady_o", 32'(ramReady_o), 32'(mReady));
    checkVal("dispStall_o", 32'(dispStall_o), 32'(!mReady));
    for (int k = 0; k < DW; k++) begin
      if (expWe[k]) begin
        checkVal($sformatf("addrWr_o lane%0d", k), 32'(addrWr_o[k*INDEX +: INDEX]), 32'(expAddr[k]));
        checkVal($sformatf("dataWr_o lane%0d", k), 32'(dataWr_o[k*WIDTH +: WIDTH]), 32'(expData[k]));
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit f, input logic [DW-1:0] we,
                               input logic [DW*INDEX-1:0] addr, input logic [DW*WIDTH-1:0] data);
    reset      = r;
    flush_i    = f;
    dispWe_i   = we;
    dispAddr_i = addr;
    dispData_i = data;
    @(posedge clk);
    modelEdge(r, f, we, addr, data);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic randomTraffic(input bit f);
    logic [DW*INDEX-1:0] a;
    for (int k = 0; k < DW; k++) a[k*INDEX +: INDEX] = INDEX'($urandom_range(0, 7));
    applyStimulus(1'b0, f, DW'($urandom), a, $urandom);
  endtask

  task automatic checkRam(input string tag);
    for (int a = 0; a < DEPTH; a++) checkVal($sformatf("%s ram[%0d]", tag, a), 32'(dutRam[a]), 32'(modelRam[a]));
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (ramReady_o !== 1'b1 && n < 40) begin
      idle(1);
      n++;
    end
    checkVal(tag, 32'(ramReady_o), 32'd1);
  endtask

  initial begin
    expWe     = '0;
    mClearing = 1'b1;
    mIdx      = 0;
    mReady    = 1'b0;
    #2;

    $display("[TB] reset and initial clear walk");
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    checkVal("reset we_o", 32'(we_o), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      randomTraffic(1'b0);
      checkVal("clear lane0 addr", 32'(addrWr_o[INDEX-1:0]), 32'(i));
      checkVal("clear we_o", 32'(we_o), 32'b0001);
      checkVal("clear ready", 32'(ramReady_o), (i == DEPTH - 1) ? 32'd1 : 32'd0);
    end
    idle(1);
    checkRam("postInit");

    $display("[TB] directed dispatch");
    applyStimulus(1'b0, 1'b0, 4'b0101, {4'd0, 4'd7, 4'd0, 4'd3}, {8'h00, 8'h5A, 8'h00, 8'hA5});
    checkVal("dir we_o", 32'(we_o), 32'b0101);
    checkVal("dir lane0 addr", 32'(addrWr_o[3:0]), 32'd3);
    checkVal("dir lane2 data", 32'(dataWr_o[23:16]), 32'h5A);
    idle(1);
    checkVal("ram[3]", 32'(dutRam[3]), 32'hA5);
    checkVal("ram[7]", 32'(dutRam[7]), 32'h5A);

    $display("[TB] collision");
    applyStimulus(1'b0, 1'b0, 4'b1011, {4'd9, 4'd5, 4'd9, 4'd9}, {8'h44, 8'h33, 8'h22, 8'h11});
    checkVal("coll we_o", 32'(we_o), 32'b1000);
    idle(1);
    checkVal("ram[9]", 32'(dutRam[9]), 32'h44);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) == 0) applyStimulus(1'b1, 1'b0, DW'($urandom), '0, '0);
      else randomTraffic($urandom_range(0, 19) == 0);
    end
    waitReady("ready after random");
    idle(1);
    checkRam("postRandom");

    $display("[TB] flush in ready with same-cycle write");
    applyStimulus(1'b0, 1'b0, 4'b0010, {4'd0, 4'd0, 4'd2, 4'd0}, {8'h0, 8'h0, 8'h77, 8'h0});
    applyStimulus(1'b0, 1'b1, 4'b0010, {4'd0, 4'd0, 4'd2, 4'd0}, {8'h0, 8'h0, 8'h33, 8'h0});
    checkVal("flush we_o", 32'(we_o), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) begin
      idle(1);
      checkVal("flush ready low", 32'(ramReady_o), 32'd0);
    end
    idle(1);
    checkVal("flush ready back", 32'(ramReady_o), 32'd1);
    idle(1);
    checkVal("ram[2] cleared", 32'(dutRam[2]), 32'd0);

    $display("[TB] flush during init");
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    idle(10);
    applyStimulus(1'b0, 1'b1, '0, '0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      idle(1);
      checkVal("reclear addr", 32'(addrWr_o[INDEX-1:0]), 32'(i));
    end
    checkVal("reclear ready", 32'(ramReady_o), 32'd1);
    idle(1);
    for (int a = 0; a < DEPTH; a++) checkVal("all zero", 32'(dutRam[a]), 32'd0);

    $display("[TB] reset in ready");
    applyStimulus(1'b1, 1'b0, 4'b1111, {4'd4, 4'd3, 4'd2, 4'd1}, 32'hDEADBEEF);
    checkVal("rst we_o", 32'(we_o), 32'd0);
    checkVal("rst ready", 32'(ramReady_o), 32'd0);
    idle(DEPTH);
    checkVal("replay ready", 32'(ramReady_o), 32'd1);
    idle(1);
    checkRam("postReplay");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stq_followingld_ctrl.md
Name: stq_followingld_ctrl

Overview:
- Write-side controller for the store-queue following-load RAM (N dispatch write ports, 1 read port, no internal reset).
- Runs the zero-fill sequence after reset and after a pipeline flush, so every entry holds a defined value.
- Gates dispatch writes until the RAM is ready and resolves same-address collisions between dispatch lanes.
- Drives the RAM write ports through one register stage; sits between dispatch and the RAM.

Parameters:
- DISPATCH_WIDTH, 4, number of dispatch lanes / RAM write ports (1..8).
- DEPTH, 16, RAM entries; must be a power of 2.
- INDEX, 4, address width; equals log2(DEPTH).
- WIDTH, 8, data width per entry.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- flush_i  input  1  recovery flush; forces a full re-clear.
- dispWe_i  input  DISPATCH_WIDTH  per-lane dispatch write request.
- dispAddr_i  input  DISPATCH_WIDTH*INDEX  per-lane address; lane k occupies bits [k*INDEX +: INDEX].
- dispData_i  input  DISPATCH_WIDTH*WIDTH  per-lane data; same packing as dispAddr_i.
- dispStall_o  output  1  dispatch must hold; requests are dropped while high.
- ramReady_o  output  1  RAM contents valid; dispatch writes accepted.
- we_o  output  DISPATCH_WIDTH  registered RAM write enables.
- addrWr_o  output  DISPATCH_WIDTH*INDEX  registered RAM write addresses.
- dataWr_o  output  DISPATCH_WIDTH*WIDTH  registered RAM write data.

Behaviour:
- Clock and reset: one clock, `clk`; reset `reset` is synchronous and active-high.
- Reset values: state=INIT, cnt=0, we_o=0, addrWr_o=0, dataWr_o=0, ramReady_o=0, dispStall_o=1.
- States and per-cycle action:
  - INIT: lane-0 output regs load we=1, addr=cnt, data=0; other lanes load we=0; cnt++.
  - READY: lane k output regs load we=dispWe_i[k] & ~killed[k], plus addr and data from lane k.
  - CLEAR: same action as INIT.
- Transitions:
  - INIT/CLEAR -> READY when cnt==DEPTH-1 is issued; cnt returns to 0.
  - READY -> CLEAR on flush_i; cnt=0.
  - flush_i in INIT/CLEAR restarts the count at 0 and moves to CLEAR.
  - reset in any state -> INIT.
  - reset has priority over flush_i.
- Output timing:
  - ramReady_o is registered: ramReady_o = (next_state==READY), captured each edge.
  - dispStall_o = ~ramReady_o.
  - After reset deasserts, clear writes appear on the ports for exactly DEPTH cycles, addresses 0..DEPTH-1 in order.
  - ramReady_o rises on the cycle the last clear write (addr DEPTH-1) is presented.
- Acceptance: a dispatch request is accepted only in a cycle where ramReady_o=1 and flush_i=0.
  - Latency 1: accepted on edge t, driven on the write ports during cycle t+1.
  - Requests in any other cycle are silently dropped.
- Flush with dispatch: if flush_i=1 in READY, all same-cycle dispatch writes are dropped. The write already registered is still presented; it is overwritten by the subsequent clear.
- Collisions: killed[k]=1 if any higher lane j>k has dispWe_i[j]=1 and the same address.
  - Highest lane (youngest) wins; at most one we_o bit per address per cycle.
  - Data of killed lanes is don't-care, but the implementation registers it anyway.
- Width rules: cnt is INDEX bits, compared against DEPTH-1; no wrap in normal operation.
- No read-path involvement; the read port goes to the RAM directly.

Decomposition:
- Shared package (lsq_ctrl_pkg): state enum (INIT, READY, CLEAR) and the reset data constant (all zeros).
- One sub-module: stq_wr_conflict_resolve (combinational killed[] generation across DISPATCH_WIDTH lanes). The FSM, counter and output registers stay in the top.

Test Plan:
- Reset release: DEPTH=16, WIDTH=8 -> cycles 1..16 show we_o=0001 with addrWr_o lane0 0..15 and data 0; ramReady_o=1 at cycle 16; dispStall_o=0 from then on.
- Dispatch write while ready: lane0 addr 3 data 0xA5, lane2 addr 7 data 0x5A -> next cycle we_o=0101 with matching addr/data; RAM read of 3 returns 0xA5 and of 7 returns 0x5A.
- Collision: lanes 0, 1, 3 all write addr 9 (data 0x11, 0x22, 0x44) -> next cycle we_o=1000; RAM[9]=0x44.
- Flush in READY with a lane-1 write to addr 2 in the same cycle -> no we_o for that write; 16 clear writes follow; RAM[2]=0; ramReady_o low for 16 cycles.
- Flush at cnt=10 during INIT -> count restarts at 0; ramReady_o rises 16 cycles after the flush cycle; every address written 0.
- Reset asserted in READY with dispWe_i=1111 -> next cycle we_o=0, ramReady_o=0; the INIT sequence is replayed.
